// File: rtl/sdram_arbit.sv
//==============================================================================
// Module   : sdram_arbit
// Purpose  : SDRAM command arbiter. Holds the bus until init completes, then
//            grants refresh/write/read one at a time and muxes their pins.
//            Optional round-robin write/read tie-break: SDRAM_ARB_RR_EN.
// Revision : 1.0
//==============================================================================
`default_nettype none

module sdram_arbit #(
    parameter int          ADDR_W  = 12,
    parameter int          BANK_W  = 2,
    parameter logic [3:0]  CMD_NOP = 4'b0111
) (
    input  logic              s_clk,
    input  logic              s_rst,
    input  logic              init_end,
    input  logic [3:0]        init_cmd,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              aref_req,
    output logic              aref_en,
    input  logic              aref_end,
    input  logic [3:0]        aref_cmd,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic              wr_req,
    output logic              wr_en,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BANK_W-1:0] wr_bank,
    input  logic              rd_req,
    output logic              rd_en,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [BANK_W-1:0] rd_bank,
    output logic [3:0]        sdram_cmd,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [BANK_W-1:0] sdram_bank,
    output logic [2:0]        arb_state
);

    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_ARBIT = 3'd1;
    localparam logic [2:0] ST_AREF  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_READ  = 3'd4;

    logic [2:0] state_q, state_d;
    logic       aref_en_q, wr_en_q, rd_en_q;

`ifdef SDRAM_ARB_RR_EN
    // 1 = read was the most recent write/read grant
    logic       rr_last_q, rr_last_d;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: begin
                if (init_end) state_d = ST_ARBIT;
            end
            ST_ARBIT: begin
                if (aref_req) begin
                    state_d = ST_AREF;
                end else if (wr_req && rd_req) begin
`ifdef SDRAM_ARB_RR_EN
                    state_d = rr_last_q ? ST_WRITE : ST_READ;
`else
                    state_d = ST_WRITE;
`endif
                end else if (wr_req) begin
                    state_d = ST_WRITE;
                end else if (rd_req) begin
                    state_d = ST_READ;
                end
            end
            ST_AREF:  if (aref_end) state_d = ST_ARBIT;
            ST_WRITE: if (wr_end)   state_d = ST_ARBIT;
            ST_READ:  if (rd_end)   state_d = ST_ARBIT;
            default:  state_d = ST_ARBIT;
        endcase
    end

`ifdef SDRAM_ARB_RR_EN
    always_comb begin
        rr_last_d = rr_last_q;
        if (state_q == ST_ARBIT && state_d == ST_WRITE) rr_last_d = 1'b0;
        if (state_q == ST_ARBIT && state_d == ST_READ)  rr_last_d = 1'b1;
    end
`endif

    // Grants are registered from the next state so they track arb_state exactly.
    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            state_q   <= ST_INIT;
            aref_en_q <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
`ifdef SDRAM_ARB_RR_EN
            rr_last_q <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            aref_en_q <= (state_d == ST_AREF);
            wr_en_q   <= (state_d == ST_WRITE);
            rd_en_q   <= (state_d == ST_READ);
`ifdef SDRAM_ARB_RR_EN
            rr_last_q <= rr_last_d;
`endif
        end
    end

    always_comb begin
        sdram_cmd  = CMD_NOP;
        sdram_addr = '0;
        sdram_bank = '0;
        case (state_q)
            ST_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                sdram_cmd  = aref_cmd;
                sdram_addr = aref_addr;
            end
            ST_WRITE: begin
                sdram_cmd  = wr_cmd;
                sdram_addr = wr_addr;
                sdram_bank = wr_bank;
            end
            ST_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_addr = rd_addr;
                sdram_bank = rd_bank;
            end
            default: begin
                sdram_cmd  = CMD_NOP;
                sdram_addr = '0;
                sdram_bank = '0;
            end
        endcase
    end

    assign aref_en   = aref_en_q;
    assign wr_en     = wr_en_q;
    assign rd_en     = rd_en_q;
    assign arb_state = state_q;

endmodule

`default_nettype wire
